// File: rtl/blob_area_perimeter.sv
// blob_area_perimeter
//   Streaming area/perimeter accumulator for a binary mask in raster order.
//   One pixel per cycle (with arbitrary valid gaps). Two-stage pipeline:
//     S1: register pixel, read line buffer (pixel above), capture left neighbour.
//     S2: accumulate area and unit edge count, latch the frame result.
//   The result is offered to a downstream divider and held while busy_in is high.
//
// Ports
//   clk_in             rising-edge clock
//   rst_in             synchronous active-high reset
//   hcount_in          pixel x (0..WIDTH-1)
//   vcount_in          pixel y (0..HEIGHT-1)
//   mask_in            1 = pixel belongs to the blob
//   pixel_valid_in     qualifies hcount_in/vcount_in/mask_in
//   busy_in            downstream busy; no result is offered while high
//   area_out           set-pixel count of the last completed frame
//   perimeter_out      edge count of the last completed frame
//   data_valid_out     one-cycle pulse announcing area_out/perimeter_out
//   frames_dropped_out (only with DROP_COUNT_EN) saturating count of results
//                      overwritten while still waiting for the divider
//
// Configuration macro: DROP_COUNT_EN

module blob_area_perimeter #(
    parameter int unsigned WIDTH  = 180,
    parameter int unsigned HEIGHT = 320,
    localparam int unsigned CW    = $clog2(WIDTH * HEIGHT) + 1,
    localparam int unsigned XW    = $clog2(WIDTH),
    localparam int unsigned YW    = $clog2(HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [XW-1:0] hcount_in,
    input  logic [YW-1:0] vcount_in,
    input  logic          mask_in,
    input  logic          pixel_valid_in,
    input  logic          busy_in,
    output logic [CW-1:0] area_out,
    output logic [CW-1:0] perimeter_out,
    output logic          data_valid_out
`ifdef DROP_COUNT_EN
    ,
    output logic [7:0]    frames_dropped_out
`endif
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);

    // ------------------------------------------------------------------
    // S1: pixel register, line buffer read/write, left neighbour
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] line_buf_q, line_buf_d;
    logic             left_m_q, left_m_d;
    logic             s1_valid_q, s1_valid_d;
    logic [XW-1:0]    s1_x_q, s1_x_d;
    logic [YW-1:0]    s1_y_q, s1_y_d;
    logic             s1_m_q, s1_m_d;
    logic             s1_l_q, s1_l_d;
    logic             s1_u_q, s1_u_d;

    always_comb begin
        line_buf_d = line_buf_q;
        left_m_d   = left_m_q;
        s1_valid_d = pixel_valid_in;
        s1_x_d     = hcount_in;
        s1_y_d     = vcount_in;
        s1_m_d     = mask_in;
        s1_l_d     = 1'b0;
        s1_u_d     = 1'b0;
        if (pixel_valid_in) begin
            line_buf_d[hcount_in] = mask_in;
            left_m_d              = mask_in;
            // Neighbours outside the frame read as unset; this also hides any
            // stale line-buffer content from a previous frame on row 0.
            s1_l_d = (hcount_in != '0) && left_m_q;
            s1_u_d = (vcount_in != '0) && line_buf_q[hcount_in];
        end
    end

    // Line buffer is deliberately not reset.
    always_ff @(posedge clk_in) begin
        line_buf_q <= line_buf_d;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            left_m_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_m_q     <= 1'b0;
            s1_l_q     <= 1'b0;
            s1_u_q     <= 1'b0;
        end else begin
            left_m_q   <= left_m_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_m_q     <= s1_m_d;
            s1_l_q     <= s1_l_d;
            s1_u_q     <= s1_u_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: saturating accumulation
    // ------------------------------------------------------------------
    logic          s2_start, s2_last;
    logic [2:0]    edge_inc;
    logic [CW-1:0] area_base, perim_base;
    logic [CW:0]   area_sum, perim_sum;
    logic [CW-1:0] area_new, perim_new;

    logic [CW-1:0] area_acc_q, area_acc_d;
    logic [CW-1:0] perim_acc_q, perim_acc_d;

    always_comb begin
        s2_start = s1_valid_q && (s1_x_q == '0) && (s1_y_q == '0);
        s2_last  = (s1_x_q == XLast) && (s1_y_q == YLast);
        edge_inc = {2'b00, s1_m_q ^ s1_l_q}
                 + {2'b00, s1_m_q ^ s1_u_q}
                 + {2'b00, s1_m_q & (s1_x_q == XLast)}
                 + {2'b00, s1_m_q & (s1_y_q == YLast)};
        // A frame start discards whatever was accumulated before it.
        area_base  = s2_start ? '0 : area_acc_q;
        perim_base = s2_start ? '0 : perim_acc_q;
        area_sum   = {1'b0, area_base} + (CW + 1)'(s1_m_q);
        perim_sum  = {1'b0, perim_base} + (CW + 1)'(edge_inc);
        area_new   = area_sum[CW] ? '1 : area_sum[CW-1:0];
        perim_new  = perim_sum[CW] ? '1 : perim_sum[CW-1:0];
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic          hold_run_q, hold_run_d;   // a new frame is accumulating during HOLD
    logic          dv_prev_q, dv_prev_d;
    logic [CW-1:0] area_out_q, area_out_d;
    logic [CW-1:0] perim_out_q, perim_out_d;
    logic          pixel_take, frame_done, pulse;
`ifdef DROP_COUNT_EN
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          drop_evt;
`endif

    always_comb begin
        state_d     = state_q;
        hold_run_d  = hold_run_q;
        area_acc_d  = area_acc_q;
        perim_acc_d = perim_acc_q;
        area_out_d  = area_out_q;
        perim_out_d = perim_out_q;
`ifdef DROP_COUNT_EN
        drop_evt    = 1'b0;
`endif

        pixel_take = s1_valid_q && (s2_start || (state_q == StAccum)
                     || ((state_q == StHold) && hold_run_q));
        frame_done = pixel_take && s2_last;
        // dv_prev_q guards the corner where a new result lands on the very
        // cycle the previous one is handed off.
        pulse      = (state_q == StHold) && !busy_in && !dv_prev_q;

        if (pixel_take) begin
            area_acc_d  = area_new;
            perim_acc_d = perim_new;
        end
        if (frame_done) begin
            area_out_d  = area_new;
            perim_out_d = perim_new;
        end

        unique case (state_q)
            StIdle: begin
                if (s2_start) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (frame_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (frame_done) begin
                    hold_run_d = 1'b0;
`ifdef DROP_COUNT_EN
                    drop_evt   = !pulse;
`endif
                end else begin
                    if (s2_start) begin
                        hold_run_d = 1'b1;
                    end
                    if (pulse) begin
                        state_d    = (hold_run_q || s2_start) ? StAccum : StIdle;
                        hold_run_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        dv_prev_d = pulse;
`ifdef DROP_COUNT_EN
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 8'hff)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            hold_run_q  <= 1'b0;
            dv_prev_q   <= 1'b0;
            area_acc_q  <= '0;
            perim_acc_q <= '0;
            area_out_q  <= '0;
            perim_out_q <= '0;
`ifdef DROP_COUNT_EN
            drop_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_run_q  <= hold_run_d;
            dv_prev_q   <= dv_prev_d;
            area_acc_q  <= area_acc_d;
            perim_acc_q <= perim_acc_d;
            area_out_q  <= area_out_d;
            perim_out_q <= perim_out_d;
`ifdef DROP_COUNT_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign area_out       = area_out_q;
    assign perimeter_out  = perim_out_q;
    assign data_valid_out = pulse;
`ifdef DROP_COUNT_EN
    assign frames_dropped_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_blob_area_perimeter.sv
// Randomized self-checking bench for blob_area_perimeter on a 32x40 frame.
// Expected area/perimeter come from a direct neighbour count over a mask array.

module tb_blob_area_perimeter;

    localparam int W  = 32;
    localparam int H  = 40;
    localparam int CW = $clog2(W * H) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    hc;
    logic [5:0]    vc;
    logic          mk;
    logic          pv;
    logic          busy;
    logic [CW-1:0] area;
    logic [CW-1:0] perim;
    logic          dv;
`ifdef DROP_COUNT_EN
    logic [7:0]    dropped;
`endif

    blob_area_perimeter #(
        .WIDTH (W),
        .HEIGHT(H)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .hcount_in     (hc),
        .vcount_in     (vc),
        .mask_in       (mk),
        .pixel_valid_in(pv),
        .busy_in       (busy),
        .area_out      (area),
        .perimeter_out (perim),
        .data_valid_out(dv)
`ifdef DROP_COUNT_EN
        ,
        .frames_dropped_out(dropped)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_cyc = 0;
    int got_a = 0;
    int got_p = 0;
    int consec = 0;
    logic dv_prev = 1'b0;
    int last_t = 0;
    bit pix [H][W];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv === 1'b1) begin
            pulses    <= pulses + 1;
            pulse_cyc <= cyc;
            got_a     <= int'(area);
            got_p     <= int'(perim);
            if (dv_prev) consec <= consec + 1;
        end
        dv_prev <= (dv === 1'b1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit px(input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
        return pix[y][x];
    endfunction

    // Area = set pixels; perimeter = sides of set pixels facing unset/outside.
    function automatic void model(output int a, output int p);
        a = 0;
        p = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (pix[y][x]) begin
                    a++;
                    p += int'(!px(x - 1, y)) + int'(!px(x + 1, y))
                       + int'(!px(x, y - 1)) + int'(!px(x, y + 1));
                end
            end
        end
    endfunction

    function automatic void fill_const(input bit v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) pix[y][x] = v;
    endfunction

    function automatic void fill_rect(input int x0, input int y0, input int x1, input int y1);
        fill_const(1'b0);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) pix[y][x] = 1'b1;
    endfunction

    function automatic void fill_rand(input int pct);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) pix[y][x] = ($urandom_range(0, 99) < pct);
    endfunction

    // Drive raster indices first..lastidx; optionally hold busy for busy_cyc
    // cycles starting with the cycle of the last pixel.
    task automatic drive_frame(input int gap_pct, input int busy_cyc,
                               input int first, input int lastidx);
        for (int idx = first; idx <= lastidx; idx++) begin
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                pv = 1'b0;
                @(posedge clk); #1;
            end
            pv = 1'b1;
            hc = 5'(idx % W);
            vc = 6'(idx / W);
            mk = pix[idx / W][idx % W];
            if (idx == lastidx && busy_cyc > 0) busy = 1'b1;
            last_t = cyc;
            @(posedge clk); #1;
        end
        pv = 1'b0;
        mk = 1'b0;
        if (busy_cyc > 0) begin
            while (cyc < last_t + busy_cyc) begin
                @(posedge clk); #1;
            end
            busy = 1'b0;
        end
    endtask

    task automatic await_pulse(input int n0);
        int k = 0;
        while (pulses == n0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input string tag, input int gap_pct, input int busy_cyc);
        int n0, ea, ep;
        n0 = pulses;
        model(ea, ep);
        drive_frame(gap_pct, busy_cyc, 0, W * H - 1);
        await_pulse(n0);
        check_eq({tag, "_pulses"}, pulses - n0, 1);
        check_eq({tag, "_area"}, got_a, ea);
        check_eq({tag, "_perim"}, got_p, ep);
        check_eq({tag, "_latency"}, pulse_cyc - last_t, (busy_cyc > 2) ? busy_cyc : 2);
        check_eq({tag, "_area_held"}, int'(area), ea);
    endtask

    initial begin
        int n0, ea, ep;
        rst = 1'b1; pv = 1'b0; hc = '0; vc = '0; mk = 1'b0; busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_area", int'(area), 0);
        check_eq("reset_perim", int'(perim), 0);
        check_eq("reset_dv", int'(dv), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill_const(1'b0);
        run_frame("zero", 0, 0);

        fill_const(1'b0);
        pix[5][5] = 1'b1;
        run_frame("single55", 0, 0);

        fill_const(1'b0);
        pix[0][0] = 1'b1;
        run_frame("single00", 0, 0);

        fill_rect(20, 30, 29, 39);
        run_frame("square", 0, 0);

        fill_const(1'b1);
        run_frame("all_ones", 0, 0);

        fill_rect(20, 30, 29, 39);
        run_frame("square_busy", 0, 12);

        // Mid-frame restart: partial random frame, then a fresh square frame.
        fill_rand(50);
        drive_frame(0, 0, 0, 500);
        fill_rect(20, 30, 29, 39);
        run_frame("restart", 10, 0);

        // Pixels not starting at (0,0) are ignored while idle.
        n0 = pulses;
        fill_const(1'b1);
        drive_frame(0, 0, W * 5, W * H - 1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("idle_pulses", pulses - n0, 0);
        check_eq("idle_area", int'(area), 100);

        // Reset mid-frame clears outputs.
        fill_rand(60);
        drive_frame(0, 0, 0, 600);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_area", int'(area), 0);
        check_eq("midrst_perim", int'(perim), 0);
        fill_rect(20, 30, 29, 39);
        run_frame("after_rst", 0, 0);

        // Two frames complete under busy: only the second result is offered.
        busy = 1'b1;
        n0 = pulses;
        fill_const(1'b0);
        pix[3][7] = 1'b1;
        drive_frame(0, 0, 0, W * H - 1);
        fill_rect(20, 30, 29, 39);
        model(ea, ep);
        drive_frame(5, 0, 0, W * H - 1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("drop_no_pulse", pulses - n0, 0);
        busy = 1'b0;
        await_pulse(n0);
        check_eq("drop_pulses", pulses - n0, 1);
        check_eq("drop_area", got_a, ea);
        check_eq("drop_perim", got_p, ep);
`ifdef DROP_COUNT_EN
        check_eq("drop_count", int'(dropped), 1);
`endif

        for (int r = 0; r < 6; r++) begin
            int bc;
            fill_rand(int'($urandom_range(10, 90)));
            bc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
            run_frame($sformatf("rand%0d", r), int'($urandom_range(0, 30)), bc);
        end

        check_eq("dv_consecutive", consec, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
